// File: rtl/multu_rebuild.sv
// Sequential unsigned multiply-accumulate p = q*b + r (inverse of divu).
// Shift-add, one multiplier bit per cycle, H iterations per operation.
module multu_rebuild #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           q,
  input  logic [WIDTH/2-1:0]         b,
  input  logic [WIDTH/2-1:0]         r,
  input  logic                       start,
  output logic [WIDTH+WIDTH/2-1:0]   p,
  output logic                       busy,
  output logic                       ready
);
  localparam int H  = WIDTH / 2;
  localparam int PW = WIDTH + H;
  localparam int CW = $clog2(H + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   mcand, acc, acc_nxt;
  logic [H-1:0]    mult;
  logic [CW-1:0]   cnt;
  logic            done;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (mult[0]) acc_nxt = acc + mcand;
        if (cnt == CW'(1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      mult  <= '0;
      cnt   <= '0;
      p     <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          mcand <= {{H{1'b0}}, q};
          mult  <= b;
          acc   <= {{WIDTH{1'b0}}, r};
          cnt   <= CW'(H);
        end
      end else begin
        acc   <= acc_nxt;
        mcand <= mcand << 1;
        mult  <= mult >> 1;
        cnt   <= cnt - CW'(1);
        // result register only moves on the completion edge
        if (done) begin
          p     <= acc_nxt;
          ready <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_multu_rebuild.sv
// Directed bench for multu_rebuild (WIDTH=8): latency, holding, start-ignore, back-to-back, reset abort.
module tb_multu_rebuild;
  localparam int WIDTH = 8;
  localparam int H     = WIDTH / 2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [WIDTH-1:0]   q = '0;
  logic [H-1:0]       b = '0;
  logic [H-1:0]       r = '0;
  logic               start = 1'b0;
  logic [WIDTH+H-1:0] p;
  logic               busy;
  logic               ready;

  int n_cmp = 0;
  int n_err = 0;

  multu_rebuild #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .q(q), .b(b), .r(r),
    .start(start), .p(p), .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // drive operands with start for one edge (E0); busy must rise
  task automatic launch(input int qv, input int bv, input int rv, input string tag);
    q = WIDTH'(qv); b = H'(bv); r = H'(rv); start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ".busy0"}, busy, 1);
    chk({tag, ".rdy0"}, ready, 0);
  endtask

  // edges E1..E(H-1) keep busy with p held, E(H) completes
  task automatic finish(input int expv, input int prevp, input string tag);
    for (int i = 1; i < H; i++) begin
      step();
      chk({tag, ".busy"}, busy, 1);
      chk({tag, ".rdy"}, ready, 0);
      chk({tag, ".hold"}, p, prevp);
    end
    step();
    chk({tag, ".done_busy"}, busy, 0);
    chk({tag, ".done_rdy"}, ready, 1);
    chk({tag, ".p"}, p, expv);
  endtask

  task automatic idle_chk(input string tag);
    step();
    chk({tag, ".rdy_off"}, ready, 0);
    chk({tag, ".idle"}, busy, 0);
  endtask

  initial begin
    step(); step();
    chk("rst.p", p, 0);
    chk("rst.busy", busy, 0);
    chk("rst.rdy", ready, 0);
    reset = 1'b0;
    idle_chk("post_rst");

    launch(4, 4, 0, "op4x4");    finish(16, 0, "op4x4");     idle_chk("op4x4");
    launch(2, 11, 2, "op24");    finish(24, 16, "op24");     idle_chk("op24");
    launch(1, 5, 1, "op6");      finish(6, 24, "op6");       idle_chk("op6");
    launch(255, 15, 15, "max");  finish(3840, 6, "max");     idle_chk("max");
    launch(0, 0, 9, "zero");     finish(9, 3840, "zero");    idle_chk("zero");

    // mid-run operand change and start pulse must be ignored
    launch(3, 3, 0, "ign");
    step();
    q = 8'd200; b = 4'd7; r = 4'd5; start = 1'b1;
    step();
    start = 1'b0;
    chk("ign.busy2", busy, 1);
    chk("ign.hold2", p, 9);
    step();
    chk("ign.busy3", busy, 1);
    step();
    chk("ign.done_rdy", ready, 1);
    chk("ign.p", p, 9);
    idle_chk("ign1");
    idle_chk("ign2");
    idle_chk("ign3");

    // start in the ready cycle is accepted at once
    launch(5, 2, 0, "b2b_a");    finish(10, 9, "b2b_a");
    launch(7, 2, 1, "b2b_b");
    chk("b2b_b.hold0", p, 10);
    finish(15, 10, "b2b_b");     idle_chk("b2b_b");

    // reset two cycles into RUN aborts with no ready
    launch(6, 3, 0, "abort");
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.rdy", ready, 0);
    chk("abort.p", p, 0);
    for (int i = 0; i < 5; i++) idle_chk("abort_quiet");

    launch(3, 5, 2, "after");    finish(17, 0, "after");     idle_chk("after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
